dmem_lsu: RTL and testbench

//  Parametrised data memory with load/store unit for the MIPS datapath; replaces the combinational word-only memory.

---
 rtl/dmem_pkg.sv | 31 +++
 rtl/dmem_ram_array.sv | 30 +++
 rtl/dmem_lsu.sv | 138 +++++++++++++
 tb/tb_dmem_lsu.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory load/store unit: access sizes, FSM states,
// the latched request record and the store lane-enable decoder.
package dmem_pkg;

  localparam int NUM_LANES = 4;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] size;
    logic       uns;
    logic [1:0] lane;
    logic       err;
  } req_t;

  function automatic logic [NUM_LANES-1:0] lane_en(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_BYTE: lane_en = 4'b0001 << lane;
      SZ_HALF: lane_en = lane[1] ? 4'b1100 : 4'b0011;
      SZ_WORD: lane_en = 4'b1111;
      default: lane_en = 4'b0000;
    endcase
  endfunction

endpackage

// File: rtl/dmem_ram_array.sv
// DEPTH x 4-lane byte-enabled RAM: clocked writes per lane, combinational read.
// Contents are never reset.
module dmem_ram_array
  import dmem_pkg::*;
#(
  parameter int    DEPTH     = 256,
  parameter string INIT_FILE = "",
  parameter int    IDX_W     = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   we,
  input  logic [NUM_LANES-1:0]   be,
  input  logic [IDX_W-1:0]       idx,
  input  logic [NUM_LANES*8-1:0] wdata,
  output logic [NUM_LANES*8-1:0] rdata
);

  logic [NUM_LANES-1:0][7:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      for (int l = 0; l < NUM_LANES; l++) begin
        if (be[l]) mem[idx][l] <= wdata[8*l +: 8];
      end
    end
  end

  assign rdata = mem[idx];

endmodule

// File: rtl/dmem_lsu.sv
// Clocked byte-addressed data memory with load/store unit and optional wait states.
// Define DMEM_MISALIGN_TRAP_EN to reject misaligned half/word accesses instead of aligning them.
module dmem_lsu
  import dmem_pkg::*;
#(
  parameter int    DATA_W      = 32,
  parameter int    DEPTH       = 256,
  parameter int    ADDR_W      = 32,
  parameter int    WAIT_CYCLES = 0,
  parameter string INIT_FILE   = ""
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH);

  state_t             state, state_nxt;
  logic [3:0]         cnt, cnt_nxt;
  req_t               req;
  logic [IDX_W-1:0]   idx;
  logic [DATA_W-1:0]  wdata_q, ram_rdata, load_val;
  logic [15:0]        rd_shift;
  logic [NUM_LANES-1:0] be;
  logic [1:0]         in_lane;
  logic               in_err, accept, access, ram_we;
  logic               unused_addr;

  assign unused_addr = ^req_addr[ADDR_W-1:IDX_W+2];

  assign req_ready = (state == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign access    = (state == BUSY) && (cnt == 4'd0);

  // Misalignment is detected as "forcing alignment changed the lane".
  always_comb begin
    in_lane = req_addr[1:0];
    case (req_size)
      SZ_WORD: in_lane = 2'b00;
      SZ_HALF: in_lane[0] = 1'b0;
      default: ;
    endcase
    in_err = (req_size == SZ_RSVD);
`ifdef DMEM_MISALIGN_TRAP_EN
    if (in_lane != req_addr[1:0]) in_err = 1'b1;
`endif
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      IDLE: if (accept) begin
        state_nxt = BUSY;
        cnt_nxt   = 4'(WAIT_CYCLES);
      end
      BUSY: if (cnt == 4'd0) state_nxt = RESP;
            else             cnt_nxt   = cnt - 4'd1;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req     <= '0;
      idx     <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      req     <= '{we: req_we, size: req_size, uns: req_unsigned, lane: in_lane, err: in_err};
      idx     <= req_addr[IDX_W+1:2];
      wdata_q <= req_wdata;
    end
  end

  // Store data stays right-justified; each lane takes its own byte of the shifted word.
  assign be     = lane_en(req.size, req.lane);
  assign ram_we = access && req.we && !req.err;

  dmem_ram_array #(
    .DEPTH     (DEPTH),
    .INIT_FILE (INIT_FILE),
    .IDX_W     (IDX_W)
  ) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .be    (be),
    .idx   (idx),
    .wdata (wdata_q << {req.lane, 3'b000}),
    .rdata (ram_rdata)
  );

  always_comb begin
    rd_shift = 16'(ram_rdata >> {req.lane, 3'b000});
    case (req.size)
      SZ_BYTE: load_val = {{(DATA_W-8){~req.uns & rd_shift[7]}}, rd_shift[7:0]};
      SZ_HALF: load_val = {{(DATA_W-16){~req.uns & rd_shift[15]}}, rd_shift[15:0]};
      default: load_val = ram_rdata;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else if (access) begin
      rsp_valid <= 1'b1;
      rsp_err   <= req.err;
      rsp_rdata <= (req.we || req.err) ? '0 : load_val;
    end else begin
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end
  end

endmodule

// File: tb/tb_dmem_lsu.sv
// Directed bench for dmem_lsu: a byte-array memory model predicts every response,
// checked on two instances (no wait states / three wait states).
module tb_dmem_lsu;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        v0 = 1'b0, v1 = 1'b0, we = 1'b0, uns = 1'b0;
  logic [1:0]  size = 2'b00;
  logic [31:0] addr = '0, wdata = '0;
  logic        rdy0, rv0, re0, rdy1, rv1, re1;
  logic [31:0] rd0, rd1;

  always #5 clk = ~clk;

  dmem_lsu #(.WAIT_CYCLES(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .req_valid(v0), .req_ready(rdy0), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(re0));

  dmem_lsu #(.WAIT_CYCLES(3)) dut1 (
    .clk(clk), .rst_n(rst_n), .req_valid(v1), .req_ready(rdy1), .req_we(we),
    .req_size(size), .req_unsigned(uns), .req_addr(addr), .req_wdata(wdata),
    .rsp_valid(rv1), .rsp_rdata(rd1), .rsp_err(re1));

  int errors = 0, checks = 0;
  logic [7:0] m0 [1024];
  logic [7:0] m1 [1024];

  bit          chk_active = 1'b0;
  int          chk_sel = 0, chk_k = 0, exp_lat = 0;
  logic [31:0] exp_rd = '0, last_rd = '0;
  logic        exp_err = 1'b0, last_err = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] rdb(input int sel, input int a);
    return sel ? m1[a] : m0[a];
  endfunction

  function automatic void wrb(input int sel, input int a, input logic [7:0] b);
    if (sel) m1[a] = b; else m0[a] = b;
  endfunction

  // Memory as 1024 bytes; misaligned accesses trap or round down depending on the build.
  function automatic void model(input int sel, input bit w, input int sz, input bit u,
                                input logic [31:0] ad, input logic [31:0] wd,
                                output logic e, output logic [31:0] r);
    int nb, a;
    bit trap;
    logic [31:0] val;
`ifdef DMEM_MISALIGN_TRAP_EN
    trap = 1'b1;
`else
    trap = 1'b0;
`endif
    e = 1'b0; r = '0;
    if (sz == 3) begin e = 1'b1; return; end
    nb = (sz == 0) ? 1 : (sz == 1) ? 2 : 4;
    a  = int'(ad % 1024);
    if ((a % nb) != 0 && trap) begin e = 1'b1; return; end
    a = a - (a % nb);
    if (w) begin
      for (int i = 0; i < nb; i++) wrb(sel, a + i, wd[8*i +: 8]);
      return;
    end
    val = '0;
    for (int i = 0; i < nb; i++) val[8*i +: 8] = rdb(sel, a + i);
    if (!u && nb < 4 && val[8*nb-1]) val = val | (32'hFFFF_FFFF << (8*nb));
    r = val;
  endfunction

  always @(negedge clk) begin
    if (chk_active) begin
      chk_k++;
      check("ready_low_busy", 32'(chk_sel ? rdy1 : rdy0), 32'd0);
      if ((chk_sel ? rv1 : rv0) === 1'b1) begin
        last_rd  = chk_sel ? rd1 : rd0;
        last_err = chk_sel ? re1 : re0;
        check("latency", 32'(chk_k), 32'(exp_lat));
        check("rdata", last_rd, exp_rd);
        check("err", 32'(last_err), 32'(exp_err));
        chk_active = 1'b0;
      end else if (chk_k > 20) begin
        check("rsp_timeout", 32'd0, 32'd1);
        chk_active = 1'b0;
      end
    end else begin
      check("idle_valid", {30'd0, rv1, rv0}, 32'd0);
      check("idle_rdata_err", rd0 | rd1 | {30'd0, re1, re0}, 32'd0);
    end
  end

  task automatic issue(input int sel, input bit w, input int sz, input bit u,
                       input logic [31:0] ad, input logic [31:0] wd,
                       input bit use_lit, input logic [31:0] lit_rd, input bit lit_err);
    logic e;
    logic [31:0] r;
    int n;
    model(sel, w, sz, u, ad, wd, e, r);
    @(negedge clk);
    we = w; size = 2'(sz); uns = u; addr = ad; wdata = wd;
    if (sel) v1 = 1'b1; else v0 = 1'b1;
    n = 0;
    while ((sel ? rdy1 : rdy0) !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    if ((sel ? rdy1 : rdy0) !== 1'b1) begin
      check("ready_timeout", 32'd0, 32'd1);
      v0 = 1'b0; v1 = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    v0 = 1'b0; v1 = 1'b0;
    addr = 32'hFFFF_FFFF; wdata = 32'h5A5A_5A5A; size = 2'b11;
    exp_rd = r; exp_err = e; chk_sel = sel; chk_k = 0; exp_lat = (sel ? 3 : 0) + 2;
    chk_active = 1'b1;
    wait (!chk_active);
    if (use_lit) begin
      check("lit_rdata", last_rd, lit_rd);
      check("lit_err", 32'(last_err), 32'(lit_err));
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    check("rst_ready0", 32'(rdy0), 32'd0);
    check("rst_ready1", 32'(rdy1), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {30'd0, rdy1, rdy0}, 32'd3);

    issue(0, 1, 2, 0, 32'h10, 32'hDEADBEEF, 0, 0, 0);
    issue(0, 0, 2, 0, 32'h10, 0, 1, 32'hDEADBEEF, 0);

    issue(0, 1, 2, 0, 32'h10, 32'h11223344, 0, 0, 0);
    issue(0, 1, 0, 0, 32'h13, 32'h00000080, 0, 0, 0);
    issue(0, 0, 0, 0, 32'h13, 0, 1, 32'hFFFFFF80, 0);
    issue(0, 0, 0, 1, 32'h13, 0, 1, 32'h00000080, 0);
    issue(0, 0, 2, 0, 32'h10, 0, 1, 32'h80223344, 0);

    issue(0, 1, 2, 0, 32'h20, 32'h55667788, 0, 0, 0);
    issue(0, 1, 1, 0, 32'h22, 32'h0000BEEF, 0, 0, 0);
    issue(0, 0, 1, 0, 32'h22, 0, 1, 32'hFFFFBEEF, 0);
    issue(0, 0, 1, 1, 32'h22, 0, 1, 32'h0000BEEF, 0);
    issue(0, 0, 2, 0, 32'h20, 0, 1, 32'hBEEF7788, 0);
    issue(0, 0, 1, 0, 32'h20, 0, 1, 32'h00007788, 0);

`ifdef DMEM_MISALIGN_TRAP_EN
    issue(0, 0, 2, 0, 32'h11, 0, 1, 32'h0, 1);
`else
    issue(0, 0, 2, 0, 32'h11, 0, 1, 32'h80223344, 0);
`endif
    issue(0, 0, 3, 0, 32'h10, 0, 1, 32'h0, 1);
    issue(0, 1, 3, 0, 32'h10, 32'hFFFFFFFF, 1, 32'h0, 1);
    issue(0, 0, 2, 0, 32'h10, 0, 1, 32'h80223344, 0);
    issue(0, 1, 1, 0, 32'h21, 32'h0000AAAA, 0, 0, 0);
    issue(0, 0, 2, 0, 32'h20, 0, 0, 0, 0);

    // Store aborted by reset while BUSY must leave the old word in place.
    issue(0, 1, 2, 0, 32'h30, 32'h12345678, 0, 0, 0);
    @(negedge clk);
    we = 1'b1; size = 2'b10; addr = 32'h30; wdata = 32'hCAFEF00D; v0 = 1'b1;
    @(posedge clk);
    #1 v0 = 1'b0;
    #2 rst_n = 1'b0;
    @(negedge clk);
    check("midrst_valid", 32'(rv0), 32'd0);
    check("midrst_ready", 32'(rdy0), 32'd0);
    @(negedge clk);
    check("midrst_ready2", 32'(rdy0), 32'd0);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_midrst", 32'(rdy0), 32'd1);
    issue(0, 0, 2, 0, 32'h30, 0, 1, 32'h12345678, 0);

    issue(1, 1, 2, 0, 32'h400, 32'hA5A5C3C3, 0, 0, 0);
    issue(1, 0, 2, 0, 32'h0, 0, 1, 32'hA5A5C3C3, 0);
    issue(1, 0, 0, 0, 32'h3, 0, 1, 32'hFFFFFFA5, 0);
    issue(1, 0, 1, 1, 32'h402, 0, 1, 32'h0000A5A5, 0);

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
